// File: rtl/pmod_spi_slave_if.sv
// CPU-side register bus of the PMOD SPI responder: held request, one-cycle done pulse.
interface pmod_spi_slave_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  input  ctrl_rdat, ctrl_done);
  modport slave  (input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/pmod_spi_slave.sv
// Mode-3 SPI responder on PMOD 1: oversampled CS_N/SCLK/MOSI, tristate MISO,
// one-byte RX/TX registers with sticky status visible over the ctrl bus.
module pmod_spi_slave #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] DEFAULT_BYTE = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  pmod_spi_slave_if.slave ctrl,
  inout  wire  PMOD_1, PMOD_2, PMOD_3, PMOD_4,
  inout  wire  PMOD_7, PMOD_8, PMOD_9, PMOD_10,
  inout  wire  PMOD2_1, PMOD2_2, PMOD2_3, PMOD2_4,
  inout  wire  PMOD2_7, PMOD2_8, PMOD2_9, PMOD2_10
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_reg, state_next;
  logic [SYNC_STAGES-1:0][2:0] sync_reg;   // {cs_n, sclk, mosi} per stage
  logic [2:0]                  prev_reg;
  logic [SYNC_STAGES:0]        prime_reg;
  logic       armed_reg, oe_reg, miso_reg, done_reg;
  logic [31:0] rdat_reg, read_val;
  logic [2:0] bit_cnt_reg;
  logic [7:0] rx_shift_reg, tx_shift_reg, rx_data_reg, tx_hold_reg, fill_reg;
  logic       rx_valid_reg, tx_full_reg, rx_overrun_reg, tx_underrun_reg;
  logic       load_tx, shift_in, shift_out, byte_done, clr_cnt;
  logic       unused_pins;

  wire cs_s      = sync_reg[SYNC_STAGES-1][2];
  wire sclk_s    = sync_reg[SYNC_STAGES-1][1];
  wire mosi_s    = sync_reg[SYNC_STAGES-1][0];
  wire cs_fall   = prev_reg[2] & ~cs_s;
  wire cs_rise   = ~prev_reg[2] & cs_s;
  wire sclk_fall = prev_reg[1] & ~sclk_s;
  wire sclk_rise = ~prev_reg[1] & sclk_s;

  wire accept     = (ctrl.ctrl_wr | ctrl.ctrl_rd) & ~done_reg;
  wire pop        = accept & ctrl.ctrl_rd & (ctrl.ctrl_addr == 8'h00);
  wire wr_tx      = accept & ctrl.ctrl_wr & (ctrl.ctrl_addr == 8'h00);
  wire wr_status  = accept & ctrl.ctrl_wr & (ctrl.ctrl_addr == 8'h04);
  wire wr_fill    = accept & ctrl.ctrl_wr & (ctrl.ctrl_addr == 8'h08);
  wire cs_active  = (state_reg == SHIFT);

  assign PMOD_3         = oe_reg ? miso_reg : 1'bz;
  assign ctrl.ctrl_done = done_reg;
  assign ctrl.ctrl_rdat = rdat_reg;
  assign unused_pins = ^{PMOD_1, PMOD_4, PMOD_9, PMOD_10, PMOD2_1, PMOD2_2, PMOD2_3,
                         PMOD2_4, PMOD2_7, PMOD2_8, PMOD2_9, PMOD2_10, ctrl.ctrl_wdat[31:8]};

  always_comb begin
    read_val = '0;
    case (ctrl.ctrl_addr)
      8'h00:   read_val = {24'b0, rx_data_reg};
      8'h04:   read_val = {27'b0, cs_active, tx_underrun_reg, rx_overrun_reg,
                           ~tx_full_reg, rx_valid_reg};
      8'h08:   read_val = {24'b0, fill_reg};
      default: read_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Entry needs 'armed' so a CS_N already low when reset lifts is not taken as a new frame.
  always_comb begin
    state_next = state_reg;
    load_tx    = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    byte_done  = 1'b0;
    clr_cnt    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall && armed_reg) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
          clr_cnt    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          clr_cnt    = 1'b1;
        end else begin
          shift_out = sclk_fall;
          shift_in  = sclk_rise;
          byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
          load_tx   = byte_done;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg        <= {SYNC_STAGES{3'b110}};
      prev_reg        <= 3'b110;
      prime_reg       <= '0;
      armed_reg       <= 1'b0;
      oe_reg          <= 1'b0;
      miso_reg        <= 1'b1;
      done_reg        <= 1'b0;
      rdat_reg        <= '0;
      bit_cnt_reg     <= '0;
      rx_shift_reg    <= '0;
      tx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      tx_hold_reg     <= '0;
      tx_full_reg     <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;
      fill_reg        <= DEFAULT_BYTE;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], {PMOD_7, PMOD_8, PMOD_2}};
      prev_reg  <= {cs_s, sclk_s, mosi_s};
      prime_reg <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
      armed_reg <= armed_reg | (prime_reg[SYNC_STAGES] & cs_s & prev_reg[2]);
      oe_reg    <= ~cs_s;
      done_reg  <= accept;
      rdat_reg  <= (accept && ctrl.ctrl_rd) ? read_val : '0;

      if (clr_cnt)       bit_cnt_reg <= '0;
      else if (shift_in) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (shift_in) rx_shift_reg <= {rx_shift_reg[6:0], mosi_s};
      if (shift_out) begin
        miso_reg     <= tx_shift_reg[7];
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      end
      if (load_tx) tx_shift_reg <= tx_full_reg ? tx_hold_reg : fill_reg;

      // A completing byte beats a same-cycle pop; the pop then reads the old byte.
      if (byte_done) begin
        rx_data_reg  <= {rx_shift_reg[6:0], mosi_s};
        rx_valid_reg <= 1'b1;
      end else if (pop) begin
        rx_valid_reg <= 1'b0;
      end

      if (byte_done && rx_valid_reg && !pop)  rx_overrun_reg <= 1'b1;
      else if (wr_status && ctrl.ctrl_wdat[2]) rx_overrun_reg <= 1'b0;
      if (load_tx && !tx_full_reg)             tx_underrun_reg <= 1'b1;
      else if (wr_status && ctrl.ctrl_wdat[3]) tx_underrun_reg <= 1'b0;

      if (wr_tx) begin
        tx_hold_reg <= ctrl.ctrl_wdat[7:0];
        tx_full_reg <= 1'b1;
      end else if (load_tx && tx_full_reg) begin
        tx_full_reg <= 1'b0;
      end
      if (wr_fill) fill_reg <= ctrl.ctrl_wdat[7:0];
    end
  end
endmodule

// File: tb/tb_pmod_spi_slave.sv
// Directed bench for pmod_spi_slave: the bench plays a mode-3 SPI master at clk/8
// and the CPU, checking register values and MISO bits against hand-computed bytes.
module tb_pmod_spi_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n = 1'b1, sclk = 1'b1, mosi = 1'b0;
  int   errors = 0, checks = 0;
  logic [31:0] rd_val;
  logic [7:0]  miso_byte;
  logic        mbit;

  always #5 clk = ~clk;

  pmod_spi_slave_if bus();

  wire p1, p2, p3, p4, p7, p8, p9, p10;
  wire [7:0] p2w;
  assign p7  = cs_n;
  assign p8  = sclk;
  assign p2  = mosi;
  assign p1  = 1'b0;
  assign p4  = 1'b0;
  assign p9  = 1'b0;
  assign p10 = 1'b0;
  assign p2w = 8'h00;
  pulldown (p3);

  pmod_spi_slave #(.SYNC_STAGES(2), .DEFAULT_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .ctrl(bus),
    .PMOD_1(p1), .PMOD_2(p2), .PMOD_3(p3), .PMOD_4(p4),
    .PMOD_7(p7), .PMOD_8(p8), .PMOD_9(p9), .PMOD_10(p10),
    .PMOD2_1(p2w[0]), .PMOD2_2(p2w[1]), .PMOD2_3(p2w[2]), .PMOD2_4(p2w[3]),
    .PMOD2_7(p2w[4]), .PMOD2_8(p2w[5]), .PMOD2_9(p2w[6]), .PMOD2_10(p2w[7])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ctrl_access(input bit wr, input bit rd, input logic [7:0] addr,
                             input logic [31:0] wdat, output logic [31:0] rdat);
    int n;
    bus.ctrl_wr = wr;  bus.ctrl_rd = rd;  bus.ctrl_addr = addr;  bus.ctrl_wdat = wdat;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!bus.ctrl_done && n < 8);
    check("ctrl_done", {31'b0, bus.ctrl_done}, 32'd1);
    rdat = bus.ctrl_rdat;
    bus.ctrl_wr = 1'b0;  bus.ctrl_rd = 1'b0;
    $display("ctrl wr=%0d rd=%0d addr=0x%02h wdat=0x%0h rdat=0x%0h", wr, rd, addr, wdat, rdat);
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    ctrl_access(1'b1, 1'b0, addr, data, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    ctrl_access(1'b0, 1'b1, addr, 32'h0, v);
    check(tag, v, exp);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    sclk = 1'b0;  mosi = b;
    tick(4);
    m = p3;
    sclk = 1'b1;
    tick(4);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
    $display("spi mosi=0x%02h miso=0x%02h", tx, rx);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;  tick(4);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;  tick(4);
  endtask

  task automatic drain();
    wr_reg(8'h04, 32'h0C);
    ctrl_access(1'b0, 1'b1, 8'h00, 32'h0, rd_val);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ctrl_wr = 1'b0;  bus.ctrl_rd = 1'b0;  bus.ctrl_addr = 8'h00;  bus.ctrl_wdat = 32'h0;
    tick(3);
    check("reset done", {31'b0, bus.ctrl_done}, 32'd0);
    check("reset rdat", bus.ctrl_rdat, 32'h0);
    check("reset miso hiz", {31'b0, p3}, 32'd0);
    reset = 1'b0;
    tick(6);
    rd_check("reset status", 8'h04, 32'h02);
    rd_check("reset fill", 8'h08, 32'hFF);
    rd_check("reset rx", 8'h00, 32'h00);

    // 1: TX 0xA5 out, 0x3C in; refill mid-frame so the end-of-byte reload finds data
    wr_reg(8'h00, 32'hA5);
    cs_low();
    for (int i = 7; i >= 4; i--) begin
      spi_bit(1'((8'h3C >> i) & 8'h01), mbit);
      miso_byte[i] = mbit;
    end
    wr_reg(8'h00, 32'h5A);
    rd_check("t1 status mid", 8'h04, 32'h10);
    for (int i = 3; i >= 0; i--) begin
      spi_bit(1'((8'h3C >> i) & 8'h01), mbit);
      miso_byte[i] = mbit;
    end
    check("t1 miso", {24'b0, miso_byte}, 32'hA5);
    rd_check("t1 status frame", 8'h04, 32'h13);
    cs_high();
    rd_check("t1 rx", 8'h00, 32'h3C);
    rd_check("t1 status after", 8'h04, 32'h02);

    // 2: nothing queued -> fill 0xFF, underrun, W1C
    cs_low();
    spi_byte(8'h00, miso_byte);
    cs_high();
    check("t2 miso", {24'b0, miso_byte}, 32'hFF);
    rd_check("t2 status", 8'h04, 32'h0B);
    wr_reg(8'h04, 32'h08);
    rd_check("t2 status w1c", 8'h04, 32'h03);
    rd_check("t2 rx", 8'h00, 32'h00);

    // 3: back-to-back bytes without a CPU read
    wr_reg(8'h08, 32'h96);
    rd_check("t3 fill", 8'h08, 32'h96);
    wr_reg(8'h00, 32'hC3);
    cs_low();
    spi_byte(8'h11, miso_byte);
    check("t3 miso1", {24'b0, miso_byte}, 32'hC3);
    spi_byte(8'h22, miso_byte);
    check("t3 miso2", {24'b0, miso_byte}, 32'h96);
    cs_high();
    rd_check("t3 status", 8'h04, 32'h0F);
    wr_reg(8'h04, 32'h0C);
    rd_check("t3 status w1c", 8'h04, 32'h03);
    rd_check("t3 rx", 8'h00, 32'h22);

    // 4: aborted partial frame, then a clean one; MISO released after CS_N rises
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, mbit);
    cs_high();
    rd_check("t4 status partial", 8'h04, 32'h0A);
    wr_reg(8'h04, 32'h08);
    wr_reg(8'h00, 32'h01);
    cs_low();
    spi_byte(8'h81, miso_byte);
    check("t4 miso", {24'b0, miso_byte}, 32'h01);
    check("t4 miso driven", {31'b0, p3}, 32'd1);
    cs_high();
    check("t4 miso hiz", {31'b0, p3}, 32'd0);
    rd_check("t4 rx", 8'h00, 32'h81);
    drain();

    // 5: CPU pop lands in the same cycle as byte completion
    cs_low();
    spi_byte(8'h5C, miso_byte);
    for (int i = 7; i >= 1; i--) spi_bit(1'((8'hE7 >> i) & 8'h01), mbit);
    sclk = 1'b0;  mosi = 1'b1;
    tick(4);
    sclk = 1'b1;
    tick(2);
    bus.ctrl_addr = 8'h00;  bus.ctrl_rd = 1'b1;
    tick(1);
    check("t5 done", {31'b0, bus.ctrl_done}, 32'd1);
    check("t5 old rx", bus.ctrl_rdat, 32'h5C);
    $display("ctrl wr=0 rd=1 addr=0x00 rdat=0x%0h (coincident)", bus.ctrl_rdat);
    bus.ctrl_rd = 1'b0;
    tick(3);
    cs_high();
    rd_check("t5 status", 8'h04, 32'h0B);
    rd_check("t5 new rx", 8'h00, 32'hE7);
    drain();

    // 6: reset in the middle of a frame
    wr_reg(8'h08, 32'h96);
    wr_reg(8'h00, 32'h77);
    cs_low();
    for (int i = 0; i < 4; i++) spi_bit(i[0], mbit);
    reset = 1'b1;
    bus.ctrl_addr = 8'h04;  bus.ctrl_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t6 done in reset", {31'b0, bus.ctrl_done}, 32'd0);
    end
    bus.ctrl_rd = 1'b0;
    reset = 1'b0;
    tick(8);
    rd_check("t6 status", 8'h04, 32'h02);
    rd_check("t6 fill", 8'h08, 32'hFF);
    rd_check("t6 rx", 8'h00, 32'h00);
    cs_high();
    rd_check("t6 status idle", 8'h04, 32'h02);
    cs_low();
    spi_byte(8'h42, miso_byte);
    cs_high();
    check("t6 miso", {24'b0, miso_byte}, 32'hFF);
    rd_check("t6 rx frame", 8'h00, 32'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pmod_spi_slave.md
Name: pmod_spi_slave

Overview:
- SPI responder on the first PMOD connector. The far end is an external SPI master; the board's own pmod_spi can serve as that master in loopback.
- Mode 3: SCLK idles high, CS active low, MSB first, 8-bit frames.
  - Master changes MOSI on SCLK falling edge and samples MISO on rising edge.
  - Slave samples MOSI on rising edge and drives MISO on falling edge.
- CPU sees a one-byte RX register, a one-byte TX holding register and sticky status flags over the standard pmod ctrl bus.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of CS/SCLK/MOSI before edge detection (min 2)
DEFAULT_BYTE, 8'hFF, reset value of the underrun fill byte register

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ctrl_wr  input  1  register write request, held until ctrl_done
ctrl_rd  input  1  register read request, held until ctrl_done
ctrl_addr  input  8  register byte address
ctrl_wdat  input  32  write data
ctrl_rdat  output  32  read data, valid in the ctrl_done cycle
ctrl_done  output  1  one-cycle completion pulse
PMOD_1..4, PMOD_7..10  inout  1 each
- PMOD_7 = CS_N in; PMOD_8 = SCLK in; PMOD_2 = MOSI in; PMOD_3 = MISO out (tristate); others input-only, unused.
PMOD2_1..4, PMOD2_7..10  inout  1 each  unused, input-only

Behaviour:
- Pads: SB_IO with no pullup.
  - CS_N/SCLK/MOSI are plain inputs.
  - MISO uses a registered-OE pad: driven only while synchronized CS_N is low, high-Z otherwise.
- Synchronizers:
  - CS_N and SCLK reset to 1; MOSI resets to 0.
  - Edges are detected on synchronized values against a one-cycle delayed copy.
  - SCLK half-period must be ≥ SYNC_STAGES+2 clk cycles; slower clk is unsupported.
- Reset values:
  - ctrl_done=0, ctrl_rdat=0, rx_data=0, rx_valid=0, tx_hold=0, tx_full=0, rx_overrun=0, tx_underrun=0, fill=DEFAULT_BYTE, bit_cnt=0, MISO OE=0, miso=1.
- Frame FSM:
  - States: IDLE (CS_N high) and SHIFT (CS_N low).
  - IDLE→SHIFT on CS_N falling edge: bit_cnt=0; tx_shift loaded with tx_hold if tx_full (clear tx_full), else fill (set tx_underrun).
  - Falling SCLK in SHIFT: miso<=tx_shift[7]; tx_shift<<=1.
  - Rising SCLK in SHIFT: rx_shift<={rx_shift[6:0],MOSI}; bit_cnt+1.
  - 8th rising edge (bit_cnt 7→0):
    - rx_data<=completed byte.
    - If rx_valid is already 1 and not popped in this cycle, set rx_overrun (new byte overwrites).
    - rx_valid<=1.
    - Reload tx_shift per the IDLE→SHIFT rule for back-to-back bytes.
  - CS_N rising edge → IDLE: partial byte discarded, bit_cnt=0, rx_valid/rx_data untouched, OE off.
  - Falling SCLK with CS_N high is ignored. Rising SCLK coincident with CS_N rising is ignored.
- Register map (reads return zero-extended values; unlisted addresses read 0 and writes are ignored):
  - 0x00 write: tx_hold<=wdat[7:0], tx_full<=1 (overwrites a pending byte silently).
  - 0x00 read: rdat=rx_data; rx_valid<=0.
  - 0x04 read: {27'b0, cs_active, tx_underrun, rx_overrun, !tx_full, rx_valid}.
  - 0x04 write: W1C; bit2 clears rx_overrun, bit3 clears tx_underrun.
  - 0x08 read/write: fill byte [7:0].
- Ctrl handshake:
  - ctrl_done pulses one cycle after wr or rd; no new access is accepted in the cycle ctrl_done=1.
  - If wr and rd are both high, both actions are performed and one pulse is issued.
  - While reset is high, ctrl_done=0.
- Simultaneous events:
  - Byte completion and 0x00 read in the same cycle: read returns the old rx_data; rx_valid stays 1 with the new byte; no overrun.
  - 0x00 write and tx_shift load in the same cycle: the load consumes the old tx_hold state; the written byte becomes pending and tx_full=1.
  - A W1C write in the same cycle as a set event: set wins.
- Reset mid-frame: everything returns to reset values immediately. After reset, the FSM enters SHIFT only on a fresh CS_N falling edge.

Test Plan:
- Write 0x00=0xA5, then master sends 0x3C at clk/8 → MISO bits 1,0,1,0,0,1,0,1; status=0x13 during frame; read 0x00=0x3C; status afterwards=0x02 (rx_valid cleared).
- No TX write, fill=0xFF, master sends 0x00 → MISO all 1s; status bit3=1; write 0x04=0x08 → bit3=0.
- Two back-to-back bytes 0x11, 0x22 with no CPU read → rx_data=0x22, rx_overrun=1; tx second byte = fill.
- CS_N deasserted after 5 SCLK rising edges → rx_valid stays 0; next full frame 0x81 received correctly; MISO high-Z after CS_N rises.
- Byte completes in the same cycle as a 0x00 read → read returns the previous byte, rx_valid=1, overrun=0.
- Reset asserted at bit 4 → all status=0x02 except cs bit; fill=0xFF; ctrl_done never pulses during reset.
